// File: rtl/matrix_bram_reader.sv
// Walks a packed row-major matrix out of matrix_bram and streams it
// as tagged valid/ready beats through a credit-limited FIFO.
module matrix_bram_reader #(
  parameter int ROWS       = 5,
  parameter int COLS       = 5,
  parameter int ADDR_WIDTH = $clog2(ROWS * COLS),
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DIM_WIDTH  =
    $clog2(((ROWS > COLS) ? ROWS : COLS) + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  rows_i,
  input  logic [DIM_WIDTH-1:0]  cols_i,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DIM_WIDTH-1:0]  out_row,
  output logic [DIM_WIDTH-1:0]  out_col,
  output logic                  out_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  typedef struct packed {
    logic                 v;
    logic [DIM_WIDTH-1:0] row;
    logic [DIM_WIDTH-1:0] col;
    logic                 last;
  } tag_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [DIM_WIDTH-1:0]  row;
    logic [DIM_WIDTH-1:0]  col;
    logic                  last;
  } beat_t;

  state_t                state;
  logic [DIM_WIDTH-1:0]  nrows;
  logic [DIM_WIDTH-1:0]  ncols;
  logic [DIM_WIDTH-1:0]  r_q;
  logic [DIM_WIDTH-1:0]  c_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  tag_t                  s0;
  tag_t                  s1;
  beat_t                 mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic                  dims_ok;
  logic                  accept;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [CW:0]           credit;
  logic [DIM_WIDTH-1:0]  cur_r;
  logic [DIM_WIDTH-1:0]  cur_c;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic [DIM_WIDTH-1:0]  lim_r;
  logic [DIM_WIDTH-1:0]  lim_c;
  logic                  cur_last;

  function automatic logic [PW-1:0] adv(
    input logic [PW-1:0] p
  );
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    dims_ok = (rows_i != '0)
           && (rows_i <= DIM_WIDTH'(ROWS))
           && (cols_i != '0)
           && (cols_i <= DIM_WIDTH'(COLS));
    accept  = (state == IDLE) && start && dims_ok;
    // Reads in flight are counted as if already in the FIFO
    credit  = (CW+1)'(count)
            + (CW+1)'(s0.v)
            + (CW+1)'(s1.v);
    issue   = accept
           || ((state == READ)
           && (credit < (CW+1)'(FIFO_DEPTH)));
    cur_r   = accept ? '0 : r_q;
    cur_c   = accept ? '0 : c_q;
    cur_idx = accept ? '0 : idx_q;
    lim_r   = accept ? rows_i - DIM_WIDTH'(1)
                     : nrows - DIM_WIDTH'(1);
    lim_c   = accept ? cols_i - DIM_WIDTH'(1)
                     : ncols - DIM_WIDTH'(1);
    cur_last = (cur_r == lim_r) && (cur_c == lim_c);
    push    = s1.v;
    pop     = out_valid && out_ready;
  end

  assign busy      = (state != IDLE);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr].data;
  assign out_row   = mem[rd_ptr].row;
  assign out_col   = mem[rd_ptr].col;
  assign out_last  = mem[rd_ptr].last && out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      nrows     <= '0;
      ncols     <= '0;
      r_q       <= '0;
      c_q       <= '0;
      idx_q     <= '0;
      s0        <= '0;
      s1        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      bram_addr <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      s1   <= s0;
      s0   <= '0;
      if (issue) begin
        s0.v      <= 1'b1;
        s0.row    <= cur_r;
        s0.col    <= cur_c;
        s0.last   <= cur_last;
        bram_addr <= cur_idx;
        idx_q     <= cur_idx + ADDR_WIDTH'(1);
        if (cur_c == lim_c) begin
          c_q <= '0;
          r_q <= cur_r + DIM_WIDTH'(1);
        end else begin
          c_q <= cur_c + DIM_WIDTH'(1);
          r_q <= cur_r;
        end
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            if (dims_ok) begin
              nrows <= rows_i;
              ncols <= cols_i;
              state <= cur_last ? DRAIN : READ;
            end else begin
              err <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue && cur_last) state <= DRAIN;
        end
        DRAIN: begin
          if (!s0.v && !s1.v
              && ((count == '0)
              || ((count == CW'(1)) && pop))) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (push) begin
        mem[wr_ptr].data <= bram_rd_data;
        mem[wr_ptr].row  <= s1.row;
        mem[wr_ptr].col  <= s1.col;
        mem[wr_ptr].last <= s1.last;
        wr_ptr <= adv(wr_ptr);
      end
      if (pop) rd_ptr <= adv(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && (count == CW'(FIFO_DEPTH)))
  );
`endif

endmodule
